// File: rtl/dscrptr_pkg.sv
// Shared FSM encoding, default cache geometry and bit-scan helper
// for the descriptor fetch scheduler.
package dscrptr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_WR   = 3'd4
  } fetchStateT;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_SLOT_W    = 2;
  localparam int MAX_VEC_W     = 32;

  // Index of the lowest set bit; 0 when the vector is empty, so callers
  // qualify the result with a reduction-OR of the same vector.
  function automatic int lowestSetBit(input logic [MAX_VEC_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/dscrptr_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo N.
// Returns a one-hot grant, its index and a valid flag.
module dscrptr_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int          cand;
  logic [N-1:0] mask;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    mask  = '0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      mask = N'(1) << cand;
      if (!valid && (|(req & mask))) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
        gnt   = mask;
      end
    end
  end

endmodule

// File: rtl/dscrptr_fetch_sched.sv
// Descriptor fetch scheduler: round-robin channel arbitration, lowest-free slot
// allocation, one outstanding fetch. Define DSCRPTR_FETCH_TIMEOUT_EN for the fetch watchdog.
//
// state   | meaning
// IDLE    | no fetch in flight; waits for a request and a free slot
// ARB     | pick channel and slot, latch address, reserve slot
// REQ     | fetchReq asserted until the engine acks
// WAIT    | acked, waiting for fetchDone
// WR      | cache write strobe plus grant or error pulse to the channel
module dscrptr_fetch_sched
  import dscrptr_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int SLOT_W      = DEF_SLOT_W,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     CLOCK,
  input  logic                     RESETN,
  input  logic [NUM_CH-1:0]        chReq,
  input  logic [NUM_CH*ADDR_W-1:0] chAddr,
  output logic [NUM_CH-1:0]        chGnt,
  output logic [NUM_CH-1:0]        chErr,
  output logic [SLOT_W-1:0]        chSlot,
  input  logic [NUM_SLOTS-1:0]     slotValid,
  output logic                     fetchReq,
  output logic [ADDR_W-1:0]        fetchAddr,
  output logic [SLOT_W-1:0]        fetchSlot,
  input  logic                     fetchAck,
  input  logic                     fetchDone,
  input  logic                     fetchErr,
  output logic                     cacheWr,
  output logic [SLOT_W-1:0]        cacheWrSlot,
  output logic                     cacheWrValid,
  output logic                     busy
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 1 || SLOT_W != $clog2(NUM_SLOTS)) begin : gParamCheck
    $error("dscrptr_fetch_sched: inconsistent parameters");
  end

  fetchStateT state, stateNxt;

  logic [CH_W-1:0]      rrPtrQ, chIdxQ, arbIdx;
  logic [NUM_CH-1:0]    arbGnt, chMask;
  logic                 arbValid;
  logic [ADDR_W-1:0]    addrQ, arbAddr;
  logic [SLOT_W-1:0]    slotQ, freeSlot;
  logic                 resvQ, errQ;
  logic [NUM_SLOTS-1:0] resvMask, freeMask;
  logic                 anyFree, inFetch, doneTake, toHit;

  dscrptr_rr_arb #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) uRrArb (
    .req   (chReq),
    .ptr   (rrPtrQ),
    .gnt   (arbGnt),
    .idx   (arbIdx),
    .valid (arbValid)
  );

  // The reserved slot stays excluded even if the cache clears its valid bit mid-fetch.
  assign resvMask = resvQ ? (NUM_SLOTS'(1) << slotQ) : '0;
  assign freeMask = ~slotValid & ~resvMask;
  assign anyFree  = |freeMask;
  assign freeSlot = SLOT_W'(lowestSetBit(MAX_VEC_W'(freeMask)));

  assign inFetch  = (state == ST_REQ) || (state == ST_WAIT);
  assign doneTake = ((state == ST_REQ) && fetchAck && fetchDone) ||
                    ((state == ST_WAIT) && fetchDone);
  assign chMask   = NUM_CH'(1) << chIdxQ;

  always_comb begin
    arbAddr = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (arbGnt[g]) arbAddr = arbAddr | chAddr[g*ADDR_W +: ADDR_W];
    end
  end

`ifdef DSCRPTR_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] toCnt;

  assign toHit = inFetch && (toCnt >= TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      toCnt <= '0;
    end else if (state == ST_ARB) begin
      toCnt <= '0;
    end else if (inFetch && (toCnt != {TO_W{1'b1}})) begin
      toCnt <= toCnt + 1'b1;
    end
  end
`else
  assign toHit = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: if ((|chReq) && anyFree) stateNxt = ST_ARB;
      // A request or free slot that vanished since IDLE sends us back idle.
      ST_ARB:  stateNxt = (arbValid && anyFree) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (fetchAck && fetchDone) stateNxt = ST_WR;
        else if (toHit)            stateNxt = ST_WR;
        else if (fetchAck)         stateNxt = ST_WAIT;
      end
      ST_WAIT: if (fetchDone || toHit) stateNxt = ST_WR;
      ST_WR:   stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fetchReq     = 1'b0;
    fetchAddr    = '0;
    fetchSlot    = '0;
    cacheWr      = 1'b0;
    cacheWrSlot  = '0;
    cacheWrValid = 1'b0;
    chGnt        = '0;
    chErr        = '0;
    chSlot       = '0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_REQ: begin
        fetchReq  = 1'b1;
        fetchAddr = addrQ;
        fetchSlot = slotQ;
      end
      ST_WR: begin
        cacheWr      = 1'b1;
        cacheWrSlot  = slotQ;
        cacheWrValid = !errQ;
        chSlot       = slotQ;
        if (errQ) chErr = chMask;
        else      chGnt = chMask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      rrPtrQ <= '0;
      chIdxQ <= '0;
      addrQ  <= '0;
      slotQ  <= '0;
      resvQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      if ((state == ST_ARB) && arbValid && anyFree) begin
        chIdxQ <= arbIdx;
        addrQ  <= arbAddr;
        slotQ  <= freeSlot;
        resvQ  <= 1'b1;
        errQ   <= 1'b0;
      end
      if (doneTake) begin
        errQ <= fetchErr;
      end else if (toHit) begin
        errQ <= 1'b1;
      end
      if (state == ST_WR) begin
        resvQ  <= 1'b0;
        rrPtrQ <= (chIdxQ == CH_W'(NUM_CH - 1)) ? '0 : chIdxQ + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dscrptr_fetch_sched.sv
// Directed bench for dscrptr_fetch_sched with a transaction-level scoreboard
// checked every cycle; covers DSCRPTR_FETCH_TIMEOUT_EN when defined.
module tb_dscrptr_fetch_sched;

  localparam int NUM_CH    = 4;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int ADDR_W    = 32;
  localparam int TO        = 16;

  logic                     CLOCK;
  logic                     RESETN;
  logic [NUM_CH-1:0]        chReq;
  logic [NUM_CH*ADDR_W-1:0] chAddr;
  logic [NUM_CH-1:0]        chGnt, chErr;
  logic [SLOT_W-1:0]        chSlot;
  logic [NUM_SLOTS-1:0]     slotValid;
  logic                     fetchReq;
  logic [ADDR_W-1:0]        fetchAddr;
  logic [SLOT_W-1:0]        fetchSlot;
  logic                     fetchAck, fetchDone, fetchErr;
  logic                     cacheWr;
  logic [SLOT_W-1:0]        cacheWrSlot;
  logic                     cacheWrValid;
  logic                     busy;

  dscrptr_fetch_sched #(
    .NUM_CH      (NUM_CH),
    .NUM_SLOTS   (NUM_SLOTS),
    .SLOT_W      (SLOT_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLOCK        (CLOCK),
    .RESETN       (RESETN),
    .chReq        (chReq),
    .chAddr       (chAddr),
    .chGnt        (chGnt),
    .chErr        (chErr),
    .chSlot       (chSlot),
    .slotValid    (slotValid),
    .fetchReq     (fetchReq),
    .fetchAddr    (fetchAddr),
    .fetchSlot    (fetchSlot),
    .fetchAck     (fetchAck),
    .fetchDone    (fetchDone),
    .fetchErr     (fetchErr),
    .cacheWr      (cacheWr),
    .cacheWrSlot  (cacheWrSlot),
    .cacheWrValid (cacheWrValid),
    .busy         (busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int nChecks = 0;
  int nErrs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Scoreboard: one fetch at a time, decided from the inputs seen in the
  // arbitration cycle (the cycle before fetchReq rises).
  function automatic int rrPick(input logic [NUM_CH-1:0] r, input int p);
    for (int k = 0; k < NUM_CH; k++) begin
      if (r[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic int lowestFree(input logic [NUM_SLOTS-1:0] v);
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!v[s]) return s;
    end
    return -1;
  endfunction

  bit                   mOut, mAck, mExpWr, mErr;
  int                   mCh, mSlot, mRr, mCnt;
  logic [ADDR_W-1:0]    mAddr;
  logic [NUM_CH-1:0]    prevReq;
  logic [NUM_SLOTS-1:0] prevValid;

  always @(negedge CLOCK) begin : compare
    bit wrNow;
    int pc, ps;
    if (!RESETN) begin
      mOut = 0; mAck = 0; mExpWr = 0; mRr = 0; mCnt = 0;
    end else begin
      wrNow  = mExpWr;
      mExpWr = 0;
      chk("m.cacheWr", cacheWr, wrNow);
      if (wrNow) begin
        chk("m.cacheWrSlot", cacheWrSlot, mSlot);
        chk("m.cacheWrValid", cacheWrValid, !mErr);
        chk("m.chGnt", chGnt, mErr ? 0 : (1 << mCh));
        chk("m.chErr", chErr, mErr ? (1 << mCh) : 0);
        chk("m.chSlot", chSlot, mSlot);
        chk("m.busy wr", busy, 1);
        mRr  = (mCh + 1) % NUM_CH;
        mOut = 0;
      end else begin
        chk("m.chGnt quiet", chGnt, 0);
        chk("m.chErr quiet", chErr, 0);
      end
      if (!mOut && fetchReq) begin
        pc = rrPick(prevReq, mRr);
        ps = lowestFree(prevValid);
        chk("m.fetch allowed", (pc >= 0 && ps >= 0), 1);
        mCh   = (pc < 0) ? 0 : pc;
        mSlot = (ps < 0) ? 0 : ps;
        mAddr = chAddr[mCh*ADDR_W +: ADDR_W];
        mOut  = 1; mAck = 0; mCnt = 0;
      end
      if (mOut) begin
        chk("m.fetchReq", fetchReq, !mAck);
        if (fetchReq) begin
          chk("m.fetchAddr", fetchAddr, mAddr);
          chk("m.fetchSlot", fetchSlot, mSlot);
        end
        chk("m.busy fetch", busy, 1);
        mCnt++;
        if (fetchDone && (mAck || (fetchReq && fetchAck))) begin
          mExpWr = 1; mErr = fetchErr;
        end
`ifdef DSCRPTR_FETCH_TIMEOUT_EN
        else if (mCnt >= TO) begin
          mExpWr = 1; mErr = 1;
        end
`endif
        if (fetchReq && fetchAck) mAck = 1;
      end
    end
    prevReq   = chReq;
    prevValid = slotValid;
  end

  task automatic resetDut();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    chk("rst.busy", busy, 0);
    chk("rst.fetchReq", fetchReq, 0);
    chk("rst.fetchAddr", fetchAddr, 0);
    chk("rst.cacheWr", cacheWr, 0);
    chk("rst.cacheWrValid", cacheWrValid, 0);
    chk("rst.chGnt", chGnt, 0);
    chk("rst.chErr", chErr, 0);
    chk("rst.chSlot", chSlot, 0);
  endtask

  task automatic serve(input int doneDly, input bit err, input bit giveDone,
                       output logic [SLOT_W-1:0] fslot);
    bit seen;
    seen  = 0;
    fslot = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (fetchReq) seen = 1;
      else tick();
    end
    chk("serve.fetchReq seen", seen, 1);
    if (seen) begin
      fslot    = fetchSlot;
      fetchAck = 1'b1;
      if (giveDone && doneDly == 0) begin
        fetchDone = 1'b1; fetchErr = err;
      end
      tick();
      fetchAck = 1'b0; fetchDone = 1'b0; fetchErr = 1'b0;
      if (giveDone && doneDly > 0) begin
        repeat (doneDly - 1) tick();
        fetchDone = 1'b1; fetchErr = err;
        tick();
        fetchDone = 1'b0; fetchErr = 1'b0;
      end
    end
  endtask

  task automatic waitWr();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (cacheWr) seen = 1;
      else tick();
    end
    chk("waitWr cacheWr seen", seen, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [SLOT_W-1:0] fs;
    int n;
    int expCh[5]   = '{0, 1, 2, 3, 0};
    int expSlot[5] = '{0, 1, 2, 3, 0};

    RESETN    = 1'b0;
    chReq     = '0;
    slotValid = '0;
    fetchAck  = 1'b0;
    fetchDone = 1'b0;
    fetchErr  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) chAddr[i*ADDR_W +: ADDR_W] = 32'h1000_0040 + 32'(i) * 32'h100;
    resetDut();

    // Single fetch, immediate ack+done: grant in the fourth cycle.
    chReq = 4'b0001;
    tick();
    chk("single.busy arb", busy, 1);
    chk("single.fetchReq arb", fetchReq, 0);
    tick();
    chk("single.fetchReq", fetchReq, 1);
    chk("single.fetchAddr", fetchAddr, 32'h1000_0040);
    chk("single.fetchSlot", fetchSlot, 0);
    fetchAck = 1'b1; fetchDone = 1'b1;
    tick();
    fetchAck = 1'b0; fetchDone = 1'b0;
    chk("single.cacheWr", cacheWr, 1);
    chk("single.cacheWrSlot", cacheWrSlot, 0);
    chk("single.cacheWrValid", cacheWrValid, 1);
    chk("single.chGnt", chGnt, 4'b0001);
    chk("single.chSlot", chSlot, 0);
    chReq = '0;
    tick();
    chk("single.idle after", busy, 0);

    // Round robin with all channels held; the bench plays the cache valid bits.
    resetDut();
    slotValid = '0;
    chReq     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(3, 0, 1, fs);
      waitWr();
      chk($sformatf("rr%0d.chGnt", i), chGnt, 32'(1) << expCh[i]);
      chk($sformatf("rr%0d.chSlot", i), chSlot, expSlot[i]);
      fs = chSlot;
      if (i == 4) chReq = '0;
      tick();
      if (i == 3) slotValid = '0;
      else        slotValid[fs] = 1'b1;
    end
    chReq = '0;
    tick();

    // Cache full: nothing may start until a slot frees up.
    slotValid = 4'b1111;
    chReq     = 4'b0010;
    repeat (5) begin
      tick();
      chk("full.fetchReq", fetchReq, 0);
      chk("full.busy", busy, 0);
    end
    slotValid = 4'b1011;
    serve(1, 0, 1, fs);
    chk("full.fetchSlot", fs, 2);
    waitWr();
    chk("full.chGnt", chGnt, 4'b0010);
    chk("full.chSlot", chSlot, 2);
    chk("full.cacheWrSlot", cacheWrSlot, 2);
    chReq = '0;
    tick();

    // Error response on ch3.
    slotValid = '0;
    chReq     = 4'b1000;
    serve(2, 1, 1, fs);
    waitWr();
    chk("err.cacheWrValid", cacheWrValid, 0);
    chk("err.chErr", chErr, 4'b1000);
    chk("err.chGnt", chGnt, 4'b0000);
    chReq = '0;
    tick();

    // Reset while waiting for done, then a stray done.
    chReq = 4'b0001;
    serve(0, 0, 0, fs);
    tick();
    chk("midrst.busy wait", busy, 1);
    chk("midrst.fetchReq wait", fetchReq, 0);
    chReq = '0;
    resetDut();
    fetchDone = 1'b1;
    tick();
    fetchDone = 1'b0;
    repeat (3) begin
      chk("midrst.no cacheWr", cacheWr, 0);
      tick();
    end

`ifdef DSCRPTR_FETCH_TIMEOUT_EN
    // Ack without done: watchdog ends the fetch with an error.
    chReq = 4'b0100;
    serve(0, 0, 0, fs);
    n = 1;
    while (!cacheWr && n < 40) begin
      tick();
      n++;
    end
    chk("to.latency", n, TO);
    chk("to.cacheWrValid", cacheWrValid, 0);
    chk("to.chErr", chErr, 4'b0100);
    chk("to.chGnt", chGnt, 0);
    chReq = '0;
    tick();
    fetchDone = 1'b1;
    tick();
    fetchDone = 1'b0;
    repeat (2) begin
      chk("to.stray done", cacheWr, 0);
      tick();
    end
`else
    // Without the watchdog the fetch waits for done indefinitely.
    chReq = 4'b0100;
    serve(0, 0, 0, fs);
    n = 0;
    repeat (30) begin
      tick();
      n++;
    end
    chk("nto.busy", busy, 1);
    chk("nto.cacheWr", cacheWr, 0);
    fetchDone = 1'b1;
    tick();
    fetchDone = 1'b0;
    chk("nto.cacheWr", cacheWr, 1);
    chk("nto.chGnt", chGnt, 4'b0100);
    chReq = '0;
    tick();
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
